// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive constants and state encoding.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_rx_ctrl_pkg;

   localparam int unsigned UART_DATA_WIDTH = 8;
   localparam int unsigned UART_OVERSAMPLE = 16;
   localparam int unsigned UART_TICK_W     = $clog2(UART_OVERSAMPLE);
   localparam int unsigned UART_BIT_W      = $clog2(UART_DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      PARITY = 3'd5
`endif
   } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous level input; reset value selectable.
module uart_rx_ctrl_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Metastability filter: two back-to-back flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit detection, mid-bit data sampling on the
// oversample tick, stop-bit check and byte-ready / framing-error pulses.
// Define UART_RX_PARITY_EN to add a parity bit state with parity_odd/parity_err.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic baud_tick,
   input  logic rx,
`ifdef UART_RX_PARITY_EN
   input  logic parity_odd,
   output logic parity_err,
`endif
   output logic rx_bit,
   output logic rx_shift,
   output logic rx_valid,
   output logic frame_err,
   output logic busy
);

   localparam logic [UART_TICK_W-1:0] TICK_MID  = UART_TICK_W'(UART_OVERSAMPLE / 2 - 1);
   localparam logic [UART_TICK_W-1:0] TICK_LAST = UART_TICK_W'(UART_OVERSAMPLE - 1);
   localparam logic [UART_BIT_W-1:0]  BIT_LAST  = UART_BIT_W'(UART_DATA_WIDTH - 1);

   uart_rx_state_t         state_q, state_d;
   logic [UART_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [UART_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                   rx_bit_q, rx_bit_d;
   logic                   rx_shift_q, rx_shift_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   busy_q, busy_d;
   logic                   rx_s;
   logic                   mid_start_c;
   logic                   mid_bit_c;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d;
   logic                   perr_pend_q, perr_pend_d;
   logic                   parity_err_q, parity_err_d;
`endif

   uart_rx_ctrl_sync #(.RST_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   assign mid_start_c = baud_tick && (tick_cnt_q == TICK_MID);
   assign mid_bit_c   = baud_tick && (tick_cnt_q == TICK_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (!rx_s) state_d = START;
         START: if (mid_start_c) state_d = rx_s ? IDLE : DATA;
         DATA: begin
            if (mid_bit_c && (bit_cnt_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (mid_bit_c) state_d = STOP;
`endif
         STOP:  if (mid_bit_c) state_d = rx_s ? IDLE : BREAK;
         BREAK: if (rx_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counter and output-pulse decode; pulses land one clk after the sampling tick.
   always_comb begin
      tick_cnt_d  = baud_tick ? tick_cnt_q + UART_TICK_W'(1) : tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = 1'b0;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      par_d        = par_q;
      perr_pend_d  = perr_pend_q;
      parity_err_d = 1'b0;
`endif
      if ((state_d != state_q) || (state_q == IDLE)) tick_cnt_d = '0;
      case (state_q)
         START: begin
            if (mid_start_c && !rx_s) begin
               bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
               par_d       = 1'b0;
               perr_pend_d = 1'b0;
`endif
            end
         end
         DATA: begin
            if (mid_bit_c) begin
               rx_bit_d   = rx_s;
               rx_shift_d = 1'b1;
               if (bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + UART_BIT_W'(1);
`ifdef UART_RX_PARITY_EN
               par_d = par_q ^ rx_s;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (mid_bit_c) perr_pend_d = (rx_s != (par_q ^ parity_odd));
         end
`endif
         STOP: begin
            if (mid_bit_c) begin
               rx_valid_d  = rx_s;
               frame_err_d = !rx_s;
`ifdef UART_RX_PARITY_EN
               parity_err_d = perr_pend_q;
`endif
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         rx_bit_q    <= 1'b0;
         rx_shift_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity accumulator and deferred parity-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_q        <= 1'b0;
         perr_pend_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_q        <= par_d;
         perr_pend_q  <= perr_pend_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign rx_bit    = rx_bit_q;
   assign rx_shift  = rx_shift_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames plus directed corner sequences.
module tb_uart_rx_ctrl;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLK  = TICK_DIV * 16;

   logic clk = 1'b0;
   logic rst;
   logic baud_tick;
   logic rx;
   logic rx_bit, rx_shift, rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
   logic parity_odd;
   logic parity_err;
   int   perr_cnt = 0;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int shift_cnt = 0, valid_cnt = 0, ferr_cnt = 0, inv_err = 0;
   int b_shift, b_valid, b_ferr;
   logic [7:0] cap = 8'h00;

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      int         exp_shift;
      int         exp_valid;
      int         exp_ferr;
   } vec_t;
   vec_t vecs[4];

   uart_rx_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .rx        (rx),
`ifdef UART_RX_PARITY_EN
      .parity_odd(parity_odd),
      .parity_err(parity_err),
`endif
      .rx_bit    (rx_bit),
      .rx_shift  (rx_shift),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Baud tick: one clk high every TICK_DIV clocks.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(posedge clk);
         #1 baud_tick = 1'b1;
         @(posedge clk);
         #1 baud_tick = 1'b0;
      end
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_shift) begin
            shift_cnt++;
            cap = {rx_bit, cap[7:1]};
         end
         if (rx_valid)  valid_cnt++;
         if (frame_err) ferr_cnt++;
         if (rx_valid && frame_err) inv_err++;
         if (rx_shift && !busy) inv_err++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) perr_cnt++;
`endif
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic snap();
      b_shift = shift_cnt;
      b_valid = valid_cnt;
      b_ferr  = ferr_cnt;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      wait_clk(BIT_CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_b,
                             input logic stop_b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (has_par) send_bit(par_b);
      send_bit(stop_b);
   endtask

   initial begin
      rx  = 1'b1;
      rst = 1'b1;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
`endif
      vecs[0] = '{data: 8'hA5, stop_b: 1'b1, exp_shift: 8, exp_valid: 1, exp_ferr: 0};
      vecs[1] = '{data: 8'h3C, stop_b: 1'b0, exp_shift: 8, exp_valid: 0, exp_ferr: 1};
      vecs[2] = '{data: 8'h55, stop_b: 1'b1, exp_shift: 8, exp_valid: 1, exp_ferr: 0};
      vecs[3] = '{data: 8'hF0, stop_b: 1'b1, exp_shift: 8, exp_valid: 1, exp_ferr: 0};

      // Reset state
      wait_clk(3);
      @(negedge clk);
      check("rst_rx_shift", int'(rx_shift), 0);
      check("rst_rx_valid", int'(rx_valid), 0);
      check("rst_frame_err", int'(frame_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_rx_bit", int'(rx_bit), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_clk(BIT_CLK);

      // Table-driven frames
      foreach (vecs[k]) begin
         snap();
         send_frame(vecs[k].data, 1'b0, 1'b0, vecs[k].stop_b);
         rx = 1'b1;
         wait_clk(BIT_CLK);
         check($sformatf("v%0d_shifts", k), shift_cnt - b_shift, vecs[k].exp_shift);
         check($sformatf("v%0d_byte", k), int'(cap), int'(vecs[k].data));
         check($sformatf("v%0d_valid", k), valid_cnt - b_valid, vecs[k].exp_valid);
         check($sformatf("v%0d_ferr", k), ferr_cnt - b_ferr, vecs[k].exp_ferr);
         check($sformatf("v%0d_busy_end", k), int'(busy), 0);
      end

      // Glitch on the line: false start returns to IDLE silently
      snap();
      rx = 1'b0;
      wait_clk(8);
      check("glitch_busy_hi", int'(busy), 1);
      wait_clk(TICK_DIV * 3 - 8);
      rx = 1'b1;
      wait_clk(2 * BIT_CLK);
      check("glitch_shifts", shift_cnt - b_shift, 0);
      check("glitch_valid", valid_cnt - b_valid, 0);
      check("glitch_busy_lo", int'(busy), 0);

      // Bad stop bit then line held low: stays in BREAK until line rises
      snap();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      wait_clk(40 * TICK_DIV);
      check("brk_shifts", shift_cnt - b_shift, 8);
      check("brk_byte", int'(cap), 8'h3C);
      check("brk_ferr", ferr_cnt - b_ferr, 1);
      check("brk_valid", valid_cnt - b_valid, 0);
      check("brk_busy_hold", int'(busy), 1);
      rx = 1'b1;
      wait_clk(10);
      check("brk_busy_release", int'(busy), 0);
      check("brk_no_new_shift", shift_cnt - b_shift, 8);
      wait_clk(BIT_CLK);

      // Back-to-back frames without idle gap
      snap();
      send_frame(8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      wait_clk(BIT_CLK);
      check("b2b_shifts", shift_cnt - b_shift, 16);
      check("b2b_valid", valid_cnt - b_valid, 2);
      check("b2b_ferr", ferr_cnt - b_ferr, 0);
      check("b2b_byte2", int'(cap), 8'hFF);

      // Reset pulse during data bit 4, remaining bits become noise
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b0;
      wait_clk(BIT_CLK / 2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_shift", int'(rx_shift), 0);
      check("mid_rst_valid", int'(rx_valid), 0);
      check("mid_rst_ferr", int'(frame_err), 0);
      check("mid_rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      wait_clk(BIT_CLK / 2 - 2);
      for (int i = 5; i < 8; i++) send_bit(1'b0);
      send_bit(1'b1);
      wait_clk(12 * BIT_CLK);
      check("noise_settled_busy", int'(busy), 0);
      snap();
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      wait_clk(BIT_CLK);
      check("post_rst_shifts", shift_cnt - b_shift, 8);
      check("post_rst_byte", int'(cap), 8'h81);
      check("post_rst_valid", valid_cnt - b_valid, 1);
      check("post_rst_ferr", ferr_cnt - b_ferr, 0);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, so the correct parity bit is 1
      begin
         int b_perr;
         b_perr = perr_cnt;
         snap();
         send_frame(8'h07, 1'b1, 1'b1, 1'b1);
         wait_clk(BIT_CLK);
         check("par_ok_valid", valid_cnt - b_valid, 1);
         check("par_ok_perr", perr_cnt - b_perr, 0);
         check("par_ok_byte", int'(cap), 8'h07);
         b_perr = perr_cnt;
         snap();
         send_frame(8'h07, 1'b1, 1'b0, 1'b1);
         wait_clk(BIT_CLK);
         check("par_bad_valid", valid_cnt - b_valid, 1);
         check("par_bad_perr", perr_cnt - b_perr, 1);
      end
`endif

      check("invariants", inv_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
